// File: rtl/aes_ldr_pkg.sv
// Shared types, constants and helpers for the aes_enc input loader.
// Optional build macro: AES_LDR_BYTESWAP_EN (used in aes_in_loader).
package aes_ldr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } ldr_state_e;

    localparam logic [1:0] KLEN_128 = 2'b00;
    localparam logic [1:0] KLEN_192 = 2'b01;
    localparam logic [1:0] KLEN_256 = 2'b10;
    localparam logic [1:0] KLEN_BAD = 2'b11;

    localparam int unsigned WORDS_PT   = 4;
    localparam int unsigned WORDS_K128 = 4;
    localparam int unsigned WORDS_K192 = 6;
    localparam int unsigned WORDS_K256 = 8;

    // Index of the final word of a transaction of the given type/length.
    function automatic logic [2:0] last_idx(input logic sel, input logic [1:0] klen);
        logic [2:0] r;
        r = 3'(WORDS_PT - 1);
        if (sel) begin
            case (klen)
                KLEN_192: r = 3'(WORDS_K192 - 1);
                KLEN_256: r = 3'(WORDS_K256 - 1);
                default:  r = 3'(WORDS_K128 - 1);
            endcase
        end
        return r;
    endfunction

    // Word slot idx sits at the MSB end first: slot 0 is bits [255:224].
    function automatic logic [255:0] put_word256(input logic [255:0] blk,
                                                 input logic [2:0]   idx,
                                                 input logic [31:0]  w);
        logic [255:0] r;
        r = blk;
        for (int i = 0; i < 8; i++) begin
            if (idx == 3'(i)) r[255-32*i -: 32] = w;
        end
        return r;
    endfunction

    // Same layout for the 128-bit plaintext block: slot 0 is bits [127:96].
    function automatic logic [127:0] put_word128(input logic [127:0] blk,
                                                 input logic [2:0]   idx,
                                                 input logic [31:0]  w);
        logic [127:0] r;
        r = blk;
        for (int i = 0; i < 4; i++) begin
            if (idx == 3'(i)) r[127-32*i -: 32] = w;
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_in_loader_if.sv
// Host-side word stream into the aes_enc loader.
// Handshake: a word transfers on a rising clock edge where in_valid=1,
// in_ready=1 and in_flush=0. in_flush is an abort and never transfers data.
interface aes_in_loader_if;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [1:0]  in_klen;
    logic        in_flush;

    modport master (output in_word, in_valid, in_sel, in_klen, in_flush,
                    input  in_ready);
    modport slave  (input  in_word, in_valid, in_sel, in_klen, in_flush,
                    output in_ready);
endinterface

// File: rtl/aes_ldr_holdoff.sv
// Loadable down-counter that blocks issue for a few cycles after each dv,
// covering the delay before aes_enc raises its busy flags.
module aes_ldr_holdoff #(
    parameter int unsigned HOLDOFF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);
    logic [2:0] cnt_q, cnt_d;

    // Next count: reload on issue, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)              cnt_d = 3'(HOLDOFF);
        else if (cnt_q != '0)  cnt_d = cnt_q - 3'd1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/aes_in_loader.sv
// Assembles 32-bit host words into aes_enc plaintext blocks and cipher keys,
// and issues them only while the core is idle.
// Build option: AES_LDR_BYTESWAP_EN byte-reverses each accepted word.
module aes_in_loader
    import aes_ldr_pkg::*;
#(
    parameter int unsigned HOLDOFF = 2
) (
    input  logic             mclk,
    input  logic             arst_n,
    aes_in_loader_if.slave   in_if,
    input  logic             busy_enc,
    input  logic             busy_exp,
    output logic [127:0]     plaintext,
    output logic [255:0]     cipherkey,
    output logic             plaintext_dv,
    output logic             cipherkey_dv,
    output logic             keylength128,
    output logic             keylength192,
    output logic             keylength256,
    output logic             key_loaded,
    output logic             err,
    output ldr_state_e       dbg_state
);
    ldr_state_e   state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic         sel_q, sel_d;
    logic [1:0]   klen_q, klen_d;
    logic [127:0] pt_q, pt_d;
    logic [255:0] ck_q, ck_d;
    logic         pt_dv_q, pt_dv_d;
    logic         ck_dv_q, ck_dv_d;
    logic [2:0]   kl_oh_q, kl_oh_d;   // {256, 192, 128}
    logic         key_loaded_q, key_loaded_d;
    logic         err_q, err_d;
    logic         ho_load, ho_zero;
    logic [31:0]  word_in;

`ifdef AES_LDR_BYTESWAP_EN
    assign word_in = {in_if.in_word[7:0],   in_if.in_word[15:8],
                      in_if.in_word[23:16], in_if.in_word[31:24]};
`else
    assign word_in = in_if.in_word;
`endif

    aes_ldr_holdoff #(.HOLDOFF(HOLDOFF)) u_holdoff (
        .clk   (mclk),
        .rst_n (arst_n),
        .load  (ho_load),
        .zero  (ho_zero)
    );

    // Next-state and datapath: collect words, then wait for an idle core.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sel_d        = sel_q;
        klen_d       = klen_q;
        pt_d         = pt_q;
        ck_d         = ck_q;
        pt_dv_d      = 1'b0;
        ck_dv_d      = 1'b0;
        kl_oh_d      = kl_oh_q;
        key_loaded_d = key_loaded_q;
        err_d        = 1'b0;
        ho_load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_if.in_valid && !in_if.in_flush) begin
                    if (in_if.in_sel && in_if.in_klen == KLEN_BAD) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d   = in_if.in_sel;
                        klen_d  = in_if.in_klen;
                        idx_d   = 3'd1;
                        state_d = COLLECT;
                        // A new key starts from zero so a short key leaves a zero tail.
                        if (in_if.in_sel) ck_d = put_word256('0, 3'd0, word_in);
                        else              pt_d = put_word128(pt_q, 3'd0, word_in);
                        if (last_idx(in_if.in_sel, in_if.in_klen) == 3'd0) begin
                            idx_d   = 3'd0;
                            state_d = ISSUE;
                        end
                    end
                end
            end
            COLLECT: begin
                if (in_if.in_flush) begin
                    idx_d   = 3'd0;
                    state_d = IDLE;
                end else if (in_if.in_valid) begin
                    if (sel_q) ck_d = put_word256(ck_q, idx_q, word_in);
                    else       pt_d = put_word128(pt_q, idx_q, word_in);
                    if (idx_q == last_idx(sel_q, klen_q)) begin
                        idx_d   = 3'd0;
                        state_d = ISSUE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ISSUE: begin
                // Flush is deliberately ignored here; the pending issue completes.
                if (!busy_enc && !busy_exp && ho_zero) begin
                    ho_load = 1'b1;
                    state_d = IDLE;
                    if (sel_q) begin
                        ck_dv_d      = 1'b1;
                        key_loaded_d = 1'b1;
                        kl_oh_d      = 3'b001 << klen_q;
                    end else if (key_loaded_q) begin
                        pt_dv_d = 1'b1;
                    end else begin
                        err_d = 1'b1;   // no key yet: drop the block
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge mclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            sel_q        <= 1'b0;
            klen_q       <= KLEN_128;
            pt_q         <= '0;
            ck_q         <= '0;
            pt_dv_q      <= 1'b0;
            ck_dv_q      <= 1'b0;
            kl_oh_q      <= 3'b001;
            key_loaded_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sel_q        <= sel_d;
            klen_q       <= klen_d;
            pt_q         <= pt_d;
            ck_q         <= ck_d;
            pt_dv_q      <= pt_dv_d;
            ck_dv_q      <= ck_dv_d;
            kl_oh_q      <= kl_oh_d;
            key_loaded_q <= key_loaded_d;
            err_q        <= err_d;
        end
    end

    assign in_if.in_ready = (state_q != ISSUE);
    assign plaintext      = pt_q;
    assign cipherkey      = ck_q;
    assign plaintext_dv   = pt_dv_q;
    assign cipherkey_dv   = ck_dv_q;
    assign keylength128   = kl_oh_q[0];
    assign keylength192   = kl_oh_q[1];
    assign keylength256   = kl_oh_q[2];
    assign key_loaded     = key_loaded_q;
    assign err            = err_q;
    assign dbg_state      = state_q;
endmodule
